// File: rtl/reg_ctrl_pkg.sv
// ============================================================================
// Module   : reg_ctrl_pkg
// Purpose  : Shared opcodes, arbiter FSM encoding and helpers for the R0/R1
//            register-file access path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_ctrl_pkg;

    localparam logic [2:0] OP_LD_R0    = 3'b000;
    localparam logic [2:0] OP_LD_R1    = 3'b001;
    localparam logic [2:0] OP_MOV_R1R0 = 3'b010;
    localparam logic [2:0] OP_MOV_R0R1 = 3'b011;
    localparam logic [2:0] OP_OUT_R0   = 3'b100;
    localparam logic [2:0] OP_OUT_R1   = 3'b101;
    localparam logic [2:0] OP_NOP      = 3'b110;

    localparam int LOCK_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    function automatic logic is_out_op(input logic [2:0] op);
        return (op == OP_OUT_R0) || (op == OP_OUT_R1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_arb_rr.sv
// ============================================================================
// Module   : reg_arb_rr
// Purpose  : Combinational round-robin picker; with ARB_LOCK_EN defined a
//            locked owner overrides the rotation until its grant budget ends.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_arb_rr
    import reg_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 2
`ifdef ARB_LOCK_EN
    ,
    parameter int LOCK_MAX = 4
`endif
) (
    input  logic [NUM_REQ-1:0]    valid,
    input  logic [1:0]            last_grant,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]    lock_req,
    input  logic                  lock_active,
    input  logic [1:0]            lock_owner,
    input  logic [LOCK_CNT_W-1:0] lock_count,
`endif
    output logic [NUM_REQ-1:0]    grant,
    output logic [1:0]            grant_idx,
    output logic                  grant_any
);

    logic [3:0] valid4;
    logic [2:0] cand;
`ifdef ARB_LOCK_EN
    logic [3:0] lock4;
    logic       lock_hit;
`endif

    always_comb begin
        valid4    = 4'(valid);
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = 3'd0;
        // Scan starting just after the last winner, wrapping modulo NUM_REQ.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant} + 3'(i);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            if (!grant_any && valid4[cand[1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[1:0];
            end
        end
`ifdef ARB_LOCK_EN
        lock4    = 4'(lock_req);
        lock_hit = lock_active && valid4[lock_owner] && lock4[lock_owner]
                   && (lock_count < LOCK_CNT_W'(LOCK_MAX));
        if (lock_hit) begin
            grant_any = 1'b1;
            grant_idx = lock_owner;
        end
`endif
        grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant[j] = grant_any && (grant_idx == 2'(j));
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_access_arbiter.sv
// ============================================================================
// Module   : reg_access_arbiter
// Purpose  : Shares the single-port R0/R1 register file between NUM_REQ
//            requesters; IDLE -> ISSUE -> RESP, one op per three cycles.
//            Optional grant locking is enabled with `define ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_access_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = 8,
    parameter int OP_W     = 3,
    parameter int LOCK_MAX = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ena,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      reg_ena,
    output logic [OP_W-1:0]           reg_opcode,
    output logic [DATA_W-1:0]         reg_wdata,
    input  logic [DATA_W-1:0]         reg_rdata,
    output logic                      busy,
    output logic [1:0]                grant_id
);

    arb_state_t          state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [1:0]          last_grant_q, last_grant_d;
    logic [1:0]          grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [1:0]          pick_idx;
    logic                pick_any;
    logic                accept;

`ifdef ARB_LOCK_EN
    logic                  lock_active_q, lock_active_d;
    logic [1:0]            lock_owner_q, lock_owner_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [3:0]            lock4;

    reg_arb_rr #(
        .NUM_REQ    (NUM_REQ),
        .LOCK_MAX   (LOCK_MAX)
    ) u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .lock_req   (req_lock),
        .lock_active(lock_active_q),
        .lock_owner (lock_owner_q),
        .lock_count (lock_cnt_q),
        .grant      (pick_gnt),
        .grant_idx  (pick_idx),
        .grant_any  (pick_any)
    );

    // Count runs of consecutive locked grants; a forced round-robin pick restarts the run.
    always_comb begin
        lock4         = 4'(req_lock);
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        lock_cnt_d    = lock_cnt_q;
        if (accept) begin
            lock_active_d = lock4[pick_idx];
            lock_owner_d  = pick_idx;
            if (lock_active_q && (lock_owner_q == pick_idx)
                && (lock_cnt_q < LOCK_CNT_W'(LOCK_MAX))) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end else begin
                lock_cnt_d = LOCK_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_active_q <= 1'b0;
            lock_owner_q  <= 2'd0;
            lock_cnt_q    <= '0;
        end else begin
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
            lock_cnt_q    <= lock_cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^{req_lock, 32'(LOCK_MAX)};

    reg_arb_rr #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_gnt),
        .grant_idx  (pick_idx),
        .grant_any  (pick_any)
    );
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wdata_d      = wdata_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        accept       = 1'b0;
        req_ready    = '0;
        unique case (state_q)
            ST_IDLE: begin
                // Ready is masked during reset so every output reads zero.
                if (ena && pick_any && !reset) begin
                    accept       = 1'b1;
                    req_ready    = pick_gnt;
                    gnt_d        = pick_gnt;
                    last_grant_d = pick_idx;
                    grant_id_d   = pick_idx;
                    state_d      = ST_ISSUE;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (pick_gnt[j]) begin
                            op_d    = req_op[j*OP_W +: OP_W];
                            wdata_d = req_data[j*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            wdata_q      <= '0;
            gnt_q        <= '0;
            last_grant_q <= 2'(NUM_REQ - 1);
            grant_id_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            wdata_q      <= wdata_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign reg_ena    = (state_q == ST_ISSUE);
    assign reg_opcode = op_q;
    assign reg_wdata  = wdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign grant_id   = grant_id_q;
    assign rsp_valid  = (state_q == ST_RESP) ? gnt_q : '0;
    // Only OUT ops return register contents; everything else answers with zero.
    assign rsp_data   = ((state_q == ST_RESP) && is_out_op(op_q)) ? reg_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_reg_access_arbiter.sv
// ============================================================================
// Module   : tb_reg_access_arbiter
// Purpose  : Self-checking bench for reg_access_arbiter with a register-file
//            stub; expectations go through a response scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_access_arbiter;
    import reg_ctrl_pkg::*;

    localparam int NUM_REQ  = 2;
    localparam int DATA_W   = 8;
    localparam int OP_W     = 3;
    localparam int LOCK_MAX = 2;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      ena   = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*OP_W-1:0]   req_op    = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]        req_lock  = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      reg_ena;
    logic [OP_W-1:0]           reg_opcode;
    logic [DATA_W-1:0]         reg_wdata;
    logic [DATA_W-1:0]         reg_rdata;
    logic                      busy;
    logic [1:0]                grant_id;

    reg_access_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clock(clock), .reset(reset), .ena(ena),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_lock(req_lock),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .reg_ena(reg_ena), .reg_opcode(reg_opcode), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .busy(busy), .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    // Register-file stub: commits on the edge ending the ISSUE cycle.
    logic [7:0] rf_r0, rf_r1;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_r0 <= 8'h00; rf_r1 <= 8'h00; reg_rdata <= 8'h00;
        end else if (reg_ena) begin
            case (reg_opcode)
                OP_LD_R0:    rf_r0 <= reg_wdata;
                OP_LD_R1:    rf_r1 <= reg_wdata;
                OP_MOV_R1R0: rf_r1 <= rf_r0;
                OP_MOV_R0R1: rf_r0 <= rf_r1;
                OP_OUT_R0:   reg_rdata <= rf_r0;
                OP_OUT_R1:   reg_rdata <= rf_r1;
                default:     reg_rdata <= 8'h00;
            endcase
        end
    end

    typedef struct { int id; logic [7:0] data; } exp_t;
    exp_t exp_q[$];

    typedef struct { int idx; logic [2:0] op; logic [7:0] data; logic [7:0] exp; } vec_t;
    vec_t vecs[14];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor: handshake -> reg_ena one cycle later -> rsp_valid one cycle after that.
    logic       acc_prev = 1'b0;
    logic       ena_prev = 1'b0;
    int         acc_id   = 0;
    logic [2:0] acc_op   = '0;
    logic [7:0] acc_data = '0;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            acc_prev = 1'b0;
            ena_prev = 1'b0;
        end else begin
            if (reg_ena !== acc_prev) begin
                fails++;
                $display("FAIL issue_timing: reg_ena=%b, expected %b", reg_ena, acc_prev);
            end
            if ((|rsp_valid) !== ena_prev) begin
                fails++;
                $display("FAIL rsp_timing: rsp_valid=%b, expected any=%b", rsp_valid, ena_prev);
            end
            if (reg_ena) begin
                tests++;
                if (reg_opcode !== acc_op || reg_wdata !== acc_data || grant_id !== acc_id[1:0]) begin
                    fails++;
                    $display("FAIL issue_fields: op=%h wdata=%h gid=%0d, expected op=%h wdata=%h gid=%0d",
                             reg_opcode, reg_wdata, grant_id, acc_op, acc_data, acc_id);
                end
            end
            if (|rsp_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b data=%h, expected none", rsp_valid, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_valid !== 2'(1 << e.id) || rsp_data !== e.data) begin
                        fails++;
                        $display("FAIL rsp: rsp_valid=%b data=%h, expected id=%0d data=%h",
                                 rsp_valid, rsp_data, e.id, e.data);
                    end
                end
            end
            if ((req_ready & ~(req_ready - 1'b1)) !== req_ready) begin
                fails++;
                $display("FAIL ready_onehot: req_ready=%b, expected at most one bit", req_ready);
            end
            acc_prev = |(req_valid & req_ready);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req_valid[j] && req_ready[j]) begin
                    acc_id   = j;
                    acc_op   = req_op[j*OP_W +: OP_W];
                    acc_data = req_data[j*DATA_W +: DATA_W];
                end
            end
            ena_prev = reg_ena;
        end
    end

    task automatic do_op(input int idx, input logic [2:0] op, input logic [7:0] data,
                         input logic [7:0] exp_rsp);
        int waited = 0;
        bit got = 1'b0;
        req_op[idx*OP_W +: OP_W]       = op;
        req_data[idx*DATA_W +: DATA_W] = data;
        req_valid[idx]                 = 1'b1;
        exp_q.push_back('{idx, exp_rsp});
        while (!got && waited < 20) begin
            @(negedge clock);
            if (req_ready[idx]) got = 1'b1;
            else waited++;
        end
        check("ready_latency", waited, 0);
        @(posedge clock); #1;
        req_valid[idx] = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int order[6];
        int n;
        int cyc;
        int bad;
        vecs[0]  = '{0, OP_LD_R0,    8'h5A, 8'h00};
        vecs[1]  = '{0, OP_OUT_R0,   8'hFF, 8'h5A};
        vecs[2]  = '{1, OP_LD_R1,    8'h33, 8'h00};
        vecs[3]  = '{0, OP_MOV_R0R1, 8'hFF, 8'h00};
        vecs[4]  = '{1, OP_OUT_R0,   8'hFF, 8'h33};
        vecs[5]  = '{0, OP_LD_R0,    8'hC3, 8'h00};
        vecs[6]  = '{1, OP_MOV_R1R0, 8'hFF, 8'h00};
        vecs[7]  = '{0, OP_OUT_R1,   8'hFF, 8'hC3};
        vecs[8]  = '{0, OP_NOP,      8'hFF, 8'h00};
        vecs[9]  = '{1, 3'b111,      8'hFF, 8'h00};
        vecs[10] = '{0, OP_OUT_R0,   8'h00, 8'hC3};
        vecs[11] = '{1, OP_LD_R1,    8'hA5, 8'h00};
        vecs[12] = '{0, OP_OUT_R1,   8'h00, 8'hA5};
        vecs[13] = '{1, OP_OUT_R1,   8'h00, 8'hA5};

        // Reset state, with a request and enable present.
        ena = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        req_valid = 2'b01;
        #1;
        check("reset_outputs",
              32'({req_ready, rsp_valid, rsp_data, reg_ena, reg_opcode, reg_wdata, busy, grant_id}), 0);
        req_valid = '0;
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].idx, vecs[i].op, vecs[i].data, vecs[i].exp);
        end
        check("table_drain", exp_q.size(), 0);

        // Contention with req0 requesting a lock; last grant was index 1.
`ifdef ARB_LOCK_EN
        order = '{0, 0, 1, 0, 0, 1};
`else
        order = '{0, 1, 0, 1, 0, 1};
`endif
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back('{order[k], (order[k] == 1) ? 8'hA5 : 8'hC3});
        end
        req_op    = {OP_OUT_R1, OP_OUT_R0};
        req_lock  = 2'b01;
        req_valid = 2'b11;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 60) begin
            @(negedge clock);
            if (|(req_valid & req_ready)) n++;
            cyc++;
        end
        @(posedge clock); #1;
        req_valid = '0;
        req_lock  = '0;
        repeat (4) @(posedge clock);
        #1;
        check("contention_grants", n, 6);
        check("contention_drain", exp_q.size(), 0);

        // ena low blocks grants; raising it accepts on the next cycle.
        ena = 1'b0;
        req_op[2:0]   = OP_OUT_R0;
        req_data[7:0] = 8'h00;
        req_valid[0]  = 1'b1;
        exp_q.push_back('{0, 8'hC3});
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (req_ready !== 2'b00 || busy !== 1'b0) bad++;
        end
        check("ena_low_no_ready", bad, 0);
        @(posedge clock); #1;
        ena = 1'b1;
        @(negedge clock);
        check("ena_rise_ready", req_ready, 2'b01);
        @(posedge clock); #1;
        req_valid = '0;
        repeat (4) @(posedge clock);
        #1;
        check("ena_drain", exp_q.size(), 0);

        // Reset while the op is in ISSUE: it is lost, no response.
        req_op[2:0]   = OP_LD_R0;
        req_data[7:0] = 8'h77;
        req_valid[0]  = 1'b1;
        @(negedge clock);
        check("rst_pre_ready", req_ready, 2'b01);
        @(posedge clock); #1;
        check("rst_issue_reg_ena", reg_ena, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_outputs",
              32'({req_ready, rsp_valid, rsp_data, reg_ena, reg_opcode, reg_wdata, busy, grant_id}), 0);
        req_valid = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("rst_no_rsp", exp_q.size(), 0);

        // After reset index 0 wins first; both loads must complete.
        req_op    = {OP_LD_R1, OP_LD_R0};
        req_data  = {8'h22, 8'h11};
        exp_q.push_back('{0, 8'h00});
        exp_q.push_back('{1, 8'h00});
        req_valid = 2'b11;
        @(negedge clock);
        check("rst_first_grant", req_ready, 2'b01);
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        cyc = 0;
        while (req_ready[1] !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check("rst_second_grant", req_ready, 2'b10);
        @(posedge clock); #1;
        req_valid = '0;
        repeat (3) @(posedge clock);
        #1;
        do_op(1, OP_OUT_R0, 8'h00, 8'h11);
        do_op(0, OP_OUT_R1, 8'h00, 8'h22);
        check("final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
